multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle instruction sequencer for the CPU core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-cycle datapath enables: PC, IR, ALU, register file and TLB. It also arbitrates the single shared memory port between instruction fetch and data access using a req/ack handshake. It sits between the IR/opcode field and the datapath, and decodes the same opcode map as the core's control unit.

## Interface
- OP_W, 6, opcode width
- ALU_W, 4, ALU control width
- CNT_W, 32, retired-instruction counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  OP_W  opcode field from IR; sampled in DECODE only
- zero  in  1  ALU zero flag; sampled in EXEC for BEQ
- mem_ack  in  1  memory access complete this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_sel_data  out  1  address mux: 0 = PC (fetch), 1 = ALU result (data)
- mem_byte  out  1  byte access (LBD/STB)
- ir_write, pc_write  out  1 each  register enables
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = EPC (IRET)
- alu_ctrl  out  ALU_W  ALU operation
- alu_src, reg_dest, mem_to_reg, reg_write  out  1 each  datapath controls
- tlb_write, iret, illegal, instr_done  out  1 each  single-cycle pulses
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset puts the FSM in IDLE with op_q = 0 and retired = 0. Every output is 0 in IDLE. IDLE always goes to FETCH on the next cycle.
- **FETCH:** mem_req=1, mem_sel_data=0, mem_we=0. Hold until mem_ack. In the ack cycle pulse ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE.
- **DECODE:** latch op into op_q and go to EXEC. Opcode classes:
  - R = 0..4
  - ADDI = 5
  - LOAD = 10, 11
  - STORE = 12, 13, 14 (MOV is a store)
  - BEQ = 20
  - JUMP = 21
  - TLBW = 30
  - IRET = 31
  - anything else is ILLEGAL
- alu_ctrl is driven in EXEC, MEM and WB, and is 0 elsewhere:
  - R: alu_ctrl = op_q
  - ADDI, LOAD, STORE: alu_ctrl = 0 (add)
  - BEQ: alu_ctrl = 1 (subtract)
- alu_src = 1 for ADDI, LOAD and STORE in EXEC/MEM/WB.
- **EXEC transitions:**
  - R, ADDI → WB.
  - LOAD, STORE → MEM.
  - BEQ → FETCH; pc_write = zero, pc_src = 1.
  - JUMP → FETCH; pc_write = 1, pc_src = 2.
  - TLBW → FETCH; pulse tlb_write.
  - IRET → FETCH; pulse iret and pc_write with pc_src = 3.
  - ILLEGAL → FETCH; pulse illegal. The instruction does not retire.
- **MEM:** mem_req=1, mem_sel_data=1, mem_we=1 for STORE, mem_byte=1 for op 10 or 12. Hold until mem_ack.
  - LOAD → WB.
  - STORE → FETCH, retiring in the ack cycle.
- **WB:** reg_write=1 for one cycle, then FETCH.
  - reg_dest=1 for R only.
  - mem_to_reg=1 for LOAD only.
  - ADDI writes rt (reg_dest=0).
- **Retire:** instr_done pulses in the last cycle of every non-illegal instruction, and retired increments in that cycle. retired wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore/Mealy combinational from state, op_q, mem_ack and zero. No output registers.
- Handshake rules:
  - While mem_req=1, mem_we, mem_sel_data and mem_byte are stable.
  - A transfer completes in a cycle where mem_req && mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - mem_req deasserts in the cycle after an ack unless the next state also requests.
- Back-to-back: FETCH immediately follows EXEC, MEM or WB. There are no idle bubbles.
- Latency with zero-wait memory, in cycles FETCH→retire:
  - R, ADDI: 4
  - LOAD: 5
  - STORE: 4
  - BEQ, JUMP, TLBW, IRET: 3
- Each wait cycle on mem_ack adds one cycle.
- rst_n low at any time, including mid-access, forces IDLE asynchronously and drops mem_req in the same cycle. There is no pending-ack memory.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (ADD..IRET values above)
  - state enum
  - pc_src encodings
  - opcode-class enum
- Sub-module op_class_decode: combinational, op → class plus illegal flag. The core's control path reuses it.

## Test plan
- Reset, then op=0 with mem_ack tied 1: IDLE→FETCH→DECODE→EXEC→WB. Sequence: mem_req in cycle 1; WB has reg_write=1, reg_dest=1, alu_ctrl=0; instr_done pulses; retired=1.
- op=11 with mem_ack delayed 3 cycles in MEM: mem_req, mem_sel_data=1 and mem_we=0 stay stable for 4 cycles. WB has mem_to_reg=1. Total 8 cycles.
- op=20: zero=1 gives pc_write=1 and pc_src=1 in EXEC. zero=0 gives pc_write=0. Both retire in 3 cycles.
- op=12: MEM shows mem_we=1 and mem_byte=1, no WB state, and the next FETCH starts the following cycle.
- op=7 (illegal): illegal pulses in EXEC, instr_done=0, retired unchanged, FSM returns to FETCH.
- Assert rst_n=0 mid-MEM with mem_ack=0: mem_req=0 immediately and every output is 0. After release, IDLE then FETCH. Also preload retired=2^32−1 and retire one instruction → retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcode map, sequencer states, PC source
// encodings and opcode classes used by the sequencer and the control path.
package cpu_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_ADDI = 5;
  localparam int OP_LBD  = 10;
  localparam int OP_LW   = 11;
  localparam int OP_STB  = 12;
  localparam int OP_SW   = 13;
  localparam int OP_MOV  = 14;
  localparam int OP_BEQ  = 20;
  localparam int OP_JMP  = 21;
  localparam int OP_TLBW = 30;
  localparam int OP_IRET = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_EPC    = 2'd3;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_JUMP,
    CLS_TLBW,
    CLS_IRET,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier shared by the sequencer and the core's
// control path; anything outside the opcode map is flagged illegal.
module op_class_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class,
  output logic            illegal
);

  always_comb begin
    case (int'(op))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_class = CLS_R;
      OP_ADDI:                               op_class = CLS_ADDI;
      OP_LBD, OP_LW:                         op_class = CLS_LOAD;
      OP_STB, OP_SW, OP_MOV:                 op_class = CLS_STORE;
      OP_BEQ:                                op_class = CLS_BEQ;
      OP_JMP:                                op_class = CLS_JUMP;
      OP_TLBW:                               op_class = CLS_TLBW;
      OP_IRET:                               op_class = CLS_IRET;
      default:                               op_class = CLS_ILLEGAL;
    endcase
    illegal = (op_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath enables
// and sharing one memory port between instruction fetch and data access.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int ALU_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             mem_byte,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             alu_src,
  output logic             reg_dest,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             tlb_write,
  output logic             iret,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] retired_q, retired_d;
  op_class_e        op_class;
  logic             op_illegal;
  logic             in_datapath;

  op_class_decode #(.OP_W(OP_W)) u_decode (
    .op       (op_q),
    .op_class (op_class),
    .illegal  (op_illegal)
  );

  assign retired   = retired_q;
  assign retired_d = retired_q + CNT_W'(instr_done);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      if (state_q == ST_DECODE) op_q <= op;
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    mem_byte     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    alu_ctrl     = '0;
    alu_src      = 1'b0;
    reg_dest     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    tlb_write    = 1'b0;
    iret         = 1'b0;
    illegal      = 1'b0;
    instr_done   = 1'b0;

    in_datapath = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
    if (in_datapath) begin
      if (op_class == CLS_R)   alu_ctrl = ALU_W'(op_q);
      if (op_class == CLS_BEQ) alu_ctrl = ALU_W'(1);
      alu_src = (op_class == CLS_ADDI) || (op_class == CLS_LOAD) || (op_class == CLS_STORE);
    end

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op_class)
          CLS_R, CLS_ADDI:     state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BEQ: begin
            pc_write   = zero;
            pc_src     = PC_SRC_BRANCH;
            instr_done = 1'b1;
          end
          CLS_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            instr_done = 1'b1;
          end
          CLS_TLBW: begin
            tlb_write  = 1'b1;
            instr_done = 1'b1;
          end
          CLS_IRET: begin
            iret       = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_EPC;
            instr_done = 1'b1;
          end
          default: illegal = op_illegal;
        endcase
      end
      ST_MEM: begin
        // Data-side controls depend only on op_q, so they hold steady while waiting.
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (op_class == CLS_STORE);
        mem_byte     = (int'(op_q) == OP_LBD) || (int'(op_q) == OP_STB);
        if (mem_ack) begin
          if (op_class == CLS_STORE) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dest   = (op_class == CLS_R);
        mem_to_reg = (op_class == CLS_LOAD);
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench: each instruction is summarised cycle by cycle
// and compared against an instruction-level model of the sequencer.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic        zero, mem_ack;
  logic        mem_req, mem_we, mem_sel_data, mem_byte, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg_dest, mem_to_reg, reg_write;
  logic        tlb_write, iret, illegal, instr_done;
  logic [31:0] retired;
  logic [19:0] s_out;
  logic [2:0]  retired_s;
  logic [19:0] m_out;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_retired = '0;

  assign m_out = {mem_req, mem_we, mem_sel_data, mem_byte, ir_write, pc_write, pc_src,
                  alu_ctrl, alu_src, reg_dest, mem_to_reg, reg_write,
                  tlb_write, iret, illegal, instr_done};

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data), .mem_byte(mem_byte),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .tlb_write(tlb_write), .iret(iret), .illegal(illegal), .instr_done(instr_done),
    .retired(retired)
  );

  // Narrow-counter twin on the same stimulus exposes counter wraparound quickly.
  multicycle_sequencer #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ack(mem_ack),
    .mem_req(s_out[19]), .mem_we(s_out[18]), .mem_sel_data(s_out[17]), .mem_byte(s_out[16]),
    .ir_write(s_out[15]), .pc_write(s_out[14]), .pc_src(s_out[13:12]), .alu_ctrl(s_out[11:8]),
    .alu_src(s_out[7]), .reg_dest(s_out[6]), .mem_to_reg(s_out[5]), .reg_write(s_out[4]),
    .tlb_write(s_out[3]), .iret(s_out[2]), .illegal(s_out[1]), .instr_done(s_out[0]),
    .retired(retired_s)
  );

  typedef enum {K_R, K_ADDI, K_LOAD, K_STORE, K_BEQ, K_JUMP, K_TLBW, K_IRET, K_ILL} kind_e;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] ir_w;
    logic [3:0] pc_w;
    logic [1:0] br_src;
    logic [3:0] reg_w;
    logic       rdest;
    logic       m2r;
    logic [7:0] fetch_req;
    logic [7:0] data_req;
    logic [7:0] we_cyc;
    logic [7:0] byte_cyc;
    logic [3:0] tlb;
    logic [3:0] iret_n;
    logic [3:0] ill;
    logic [3:0] done;
    logic [3:0] alu_exec;
    logic       alu_src_exec;
    logic [7:0] fetch_alu;
    logic [7:0] twin_diff;
  } obs_t;

  function automatic kind_e kind_of(input int o);
    if (o >= 0 && o <= 4)          return K_R;
    if (o == 5)                    return K_ADDI;
    if (o == 10 || o == 11)        return K_LOAD;
    if (o >= 12 && o <= 14)        return K_STORE;
    if (o == 20)                   return K_BEQ;
    if (o == 21)                   return K_JUMP;
    if (o == 30)                   return K_TLBW;
    if (o == 31)                   return K_IRET;
    return K_ILL;
  endfunction

  // Instruction-level expectations: latency table plus wait cycles and pulse counts.
  function automatic obs_t expect_obs(input int o, input int fw, input int mw, input logic z);
    obs_t  e;
    kind_e k;
    bit    is_mem;
    int    base;
    e      = '0;
    k      = kind_of(o);
    is_mem = (k == K_LOAD) || (k == K_STORE);
    case (k)
      K_R, K_ADDI, K_STORE: base = 4;
      K_LOAD:               base = 5;
      default:              base = 3;
    endcase
    e.cycles       = 8'(base + fw + (is_mem ? mw : 0));
    e.ir_w         = 4'd1;
    e.pc_w         = 4'(1 + ((k == K_BEQ && z) ? 1 : 0) + ((k == K_JUMP || k == K_IRET) ? 1 : 0));
    e.br_src       = (k == K_BEQ && z) ? 2'd1 : (k == K_JUMP) ? 2'd2 : (k == K_IRET) ? 2'd3 : 2'd0;
    e.reg_w        = (k == K_R || k == K_ADDI || k == K_LOAD) ? 4'd1 : 4'd0;
    e.rdest        = (k == K_R);
    e.m2r          = (k == K_LOAD);
    e.fetch_req    = 8'(fw + 1);
    e.data_req     = is_mem ? 8'(mw + 1) : 8'd0;
    e.we_cyc       = (k == K_STORE) ? 8'(mw + 1) : 8'd0;
    e.byte_cyc     = (o == 10 || o == 12) ? 8'(mw + 1) : 8'd0;
    e.tlb          = (k == K_TLBW) ? 4'd1 : 4'd0;
    e.iret_n       = (k == K_IRET) ? 4'd1 : 4'd0;
    e.ill          = (k == K_ILL) ? 4'd1 : 4'd0;
    e.done         = (k == K_ILL) ? 4'd0 : 4'd1;
    e.alu_exec     = (k == K_R) ? 4'(o) : (k == K_BEQ) ? 4'd1 : 4'd0;
    e.alu_src_exec = (k == K_ADDI) || (k == K_LOAD) || (k == K_STORE);
    return e;
  endfunction

  // Entered just after a rising edge with the DUT expected to be in FETCH.
  task automatic run_instr(input int o, input int fw, input int mw, input logic z);
    obs_t ob, ex;
    int   ir_cyc, fcnt, mcnt;
    bit   ended;
    ob = '0; ir_cyc = -10; fcnt = fw; mcnt = mw; ended = 0;
    total++;
    if (mem_req === 1'b1 && mem_sel_data === 1'b0) passed++;
    else $display("FAIL fetch_start op=%0d: mem_req=%b mem_sel_data=%b, required 1/0",
                  o, mem_req, mem_sel_data);
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      if (mem_req && !mem_sel_data) begin
        mem_ack = (fcnt == 0);
        if (fcnt > 0) fcnt--;
      end else if (mem_req) begin
        mem_ack = (mcnt == 0);
        if (mcnt > 0) mcnt--;
      end else begin
        mem_ack = 1'($urandom);
      end
      op   = (cyc == ir_cyc + 1) ? 6'(o) : 6'($urandom);
      zero = (cyc == ir_cyc + 2) ? z : 1'($urandom);
      #1;
      if (cyc == ir_cyc + 2) begin
        ob.alu_exec     = alu_ctrl;
        ob.alu_src_exec = alu_src;
      end
      if (ir_write) begin ob.ir_w += 1; ir_cyc = cyc; end
      if (pc_write) ob.pc_w += 1;
      if (pc_write && !ir_write) ob.br_src = pc_src;
      if (reg_write) ob.reg_w += 1;
      if (reg_dest) ob.rdest = 1'b1;
      if (mem_to_reg) ob.m2r = 1'b1;
      if (mem_req && !mem_sel_data) begin
        ob.fetch_req += 1;
        if (alu_ctrl != 4'd0) ob.fetch_alu += 1;
      end
      if (mem_req && mem_sel_data) ob.data_req += 1;
      if (mem_we) ob.we_cyc += 1;
      if (mem_byte) ob.byte_cyc += 1;
      if (tlb_write) ob.tlb += 1;
      if (iret) ob.iret_n += 1;
      if (illegal) ob.ill += 1;
      if (instr_done) ob.done += 1;
      if (s_out !== m_out) ob.twin_diff += 1;
      ob.cycles = 8'(cyc + 1);
      if (instr_done || illegal) ended = 1;
      @(posedge clk);
      #1;
    end
    total++;
    if (ended) passed++;
    else $display("FAIL timeout op=%0d: no instr_done/illegal within 40 cycles, required one", o);
    ex = expect_obs(o, fw, mw, z);
    total++;
    if (ob === ex) passed++;
    else $display("FAIL instr op=%0d fw=%0d mw=%0d z=%b: got %p required %p", o, fw, mw, z, ob, ex);
    if (kind_of(o) != K_ILL) exp_retired++;
    total++;
    if (retired === exp_retired && retired_s === exp_retired[2:0]) passed++;
    else $display("FAIL retired op=%0d: got %0d/%0d required %0d/%0d",
                  o, retired, retired_s, exp_retired, exp_retired[2:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_out === '0 && retired === '0 && s_out === '0 && retired_s === '0) passed++;
    else $display("FAIL reset_outputs: got %h/%0d required 0/0", m_out, retired);
    #1 rst_n = 1'b1;
    mem_ack = 1'b1;
    #1;
    total++;
    if (m_out === '0) passed++;
    else $display("FAIL idle_outputs: got %h required 0", m_out);
    exp_retired = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_r_type;
    run_instr(0, 0, 0, 1'b0);
    run_instr(3, 1, 0, 1'b1);
    run_instr(5, 0, 0, 1'b0);
  endtask

  task automatic test_load_wait;
    run_instr(11, 0, 3, 1'b0);
    run_instr(10, 2, 1, 1'b1);
  endtask

  task automatic test_beq;
    run_instr(20, 0, 0, 1'b1);
    run_instr(20, 0, 0, 1'b0);
  endtask

  task automatic test_store_byte;
    run_instr(12, 0, 0, 1'b0);
    run_instr(14, 1, 2, 1'b0);
  endtask

  task automatic test_control_ops;
    run_instr(21, 0, 0, 1'b0);
    run_instr(30, 1, 0, 1'b1);
    run_instr(31, 0, 0, 1'b0);
  endtask

  task automatic test_illegal;
    run_instr(7, 0, 0, 1'b0);
    run_instr(63, 1, 0, 1'b1);
  endtask

  task automatic test_wrap;
    while (exp_retired[2:0] != 3'd7) run_instr(1, 0, 0, 1'b0);
    run_instr(4, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int legal_ops[15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 20, 21, 30, 31};
    int o;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) o = int'($urandom_range(0, 63));
      else o = legal_ops[$urandom_range(0, 14)];
      run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_mem;
    bit reached = 0;
    for (int n = 0; n < 20 && !reached; n++) begin
      op = 6'd11; zero = 1'b0;
      mem_ack = mem_req && !mem_sel_data;
      #1;
      if (mem_req && mem_sel_data) reached = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    total++;
    if (reached) passed++;
    else $display("FAIL reach_mem: data request not seen within 20 cycles, required by op 11");
    rst_n = 1'b0;
    #1;
    total++;
    if (m_out === '0 && retired === '0 && s_out === '0 && retired_s === '0) passed++;
    else $display("FAIL reset_mid_mem: got %h/%0d required 0/0", m_out, retired);
    exp_retired = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mem_ack = 1'b1;
    #1;
    total++;
    if (m_out === '0) passed++;
    else $display("FAIL idle_after_reset: got %h required 0", m_out);
    @(posedge clk);
    #1;
    run_instr(11, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_r_type;
    test_load_wait;
    test_beq;
    test_store_byte;
    test_control_ops;
    test_illegal;
    test_wrap;
    test_back_to_back;
    test_reset_mid_mem;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
